// File: rtl/serial_subtractor_8bit.sv
// Bit-serial subtractor: diff = A - B - borrow_in, one bit per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             borrow_out
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] diff_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             br_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             borrow_out_reg;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_reg;
`endif

  // Full-subtractor cell on the current LSBs of the shift registers.
  logic d_bit;
  logic br_next;

  always_comb begin
    d_bit   = a_sh_reg[0] ^ b_sh_reg[0] ^ br_reg;
    br_next = (~a_sh_reg[0] & b_sh_reg[0]) | (~(a_sh_reg[0] ^ b_sh_reg[0]) & br_reg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      a_sh_reg       <= '0;
      b_sh_reg       <= '0;
      diff_reg       <= '0;
      cnt_reg        <= '0;
      br_reg         <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      borrow_out_reg <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_reg        <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            a_sh_reg  <= A;
            b_sh_reg  <= B;
            br_reg    <= borrow_in;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          diff_reg <= {d_bit, diff_reg[WIDTH-1:1]};
          a_sh_reg <= a_sh_reg >> 1;
          b_sh_reg <= b_sh_reg >> 1;
          br_reg   <= br_next;
          if (cnt_reg == LAST_BIT) begin
            // Final bit: br_reg is the borrow into the MSB, br_next the borrow out.
            borrow_out_reg <= br_next;
`ifdef SERIAL_SUB_OVF_EN
            ovf_reg        <= br_reg ^ br_next;
`endif
            cnt_reg        <= '0;
            done_reg       <= 1'b1;
            state_reg      <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign diff       = diff_reg;
  assign borrow_out = borrow_out_reg;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf        = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// Directed and random checks of serial_subtractor_8bit against an arithmetic model.
module tb_serial_subtractor_8bit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         borrow_in = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int fails  = 0;

  serial_subtractor_8bit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .A          (A),
    .B          (B),
    .borrow_in  (borrow_in),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
`ifdef SERIAL_SUB_OVF_EN
    .ovf        (ovf),
`endif
    .borrow_out (borrow_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one operation. mode 1 pulses a second start mid-shift; mode 2 resets mid-shift.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bin, input int mode);
    logic [W:0] full;
    int         s;
    int         busy_cnt;
    int         done_cnt;
    int         done_pos;
    logic [W-1:0] diff_at_done;
    logic         bo_at_done;
    logic         ovf_at_done;
    logic         exp_ovf;
    full    = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
    s       = $signed(a) - $signed(b) - int'(bin);
    exp_ovf = (s < -(2 ** (W-1))) || (s > (2 ** (W-1)) - 1);
    busy_cnt = 0; done_cnt = 0; done_pos = -1;
    diff_at_done = 'x; bo_at_done = 1'bx; ovf_at_done = 1'bx;

    @(negedge clk);
    A = a; B = b; borrow_in = bin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = ~a; B = ~b; borrow_in = ~bin;
    for (int i = 0; i < 4 * W + 8; i++) begin
      if (!busy) break;
      if (done) begin
        done_cnt++;
        done_pos     = busy_cnt;
        diff_at_done = diff;
        bo_at_done   = borrow_out;
`ifdef SERIAL_SUB_OVF_EN
        ovf_at_done  = ovf;
`endif
      end
      busy_cnt++;
      if (mode == 1 && busy_cnt == 3) begin
        A = 8'd1; B = 8'd1; borrow_in = 1'b0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (mode == 2 && busy_cnt == 4) begin
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_diff", 32'(diff), 32'd0);
        check("rst_mid_bo",   32'(borrow_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("op A=%0h B=%0h bin=%0d aborted by reset", a, b, bin);
        return;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_cycles", 32'(busy_cnt), 32'(W + 1));
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("done_pos",    32'(done_pos), 32'(W));
    check("diff",        32'(diff_at_done), 32'(full[W-1:0]));
    check("borrow_out",  32'(bo_at_done), 32'(full[W]));
`ifdef SERIAL_SUB_OVF_EN
    check("ovf",         32'(ovf_at_done), 32'(exp_ovf));
`endif
    $display("op A=%0h B=%0h bin=%0d -> diff=%0h bo=%0b (exp %0h/%0b) ovf_exp=%0b",
             a, b, bin, diff_at_done, bo_at_done, full[W-1:0], full[W], exp_ovf);
  endtask

  initial begin
    logic [W-1:0] held;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bo",   32'(borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf",  32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;

    run_op(8'h00, 8'h00, 1'b0, 0);
    run_op(8'h00, 8'h01, 1'b0, 0);
    run_op(8'h80, 8'h01, 1'b0, 0);
    run_op(8'h80, 8'h80, 1'b1, 0);
    run_op(8'h09, 8'h04, 1'b0, 0);
    run_op(8'hFF, 8'hFF, 1'b1, 0);
    run_op(8'hFF, 8'h00, 1'b0, 0);
    run_op(8'd200, 8'd100, 1'b0, 1);

    // Result must hold while idle even as inputs change.
    held = diff;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      A = W'($urandom); B = W'($urandom);
    end
    check("idle_hold_diff", 32'(diff), 32'(held));
    check("idle_busy", 32'(busy), 32'd0);

    run_op(8'd37, 8'd90, 1'b0, 2);
    run_op(8'h04, 8'h05, 1'b0, 0);

    for (int i = 0; i < 24; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_subtractor_8bit.md
Name: serial_subtractor_8bit

Overview:
- Bit-serial subtractor: computes diff = A - B - borrow_in one bit per clock, LSB first.
- Inverse counterpart of the 8-bit ripple-carry adder. Trades latency for a single full-subtractor cell plus shift registers.
- Start/busy/done handshake. Sits beside the adder in the lab-06 arithmetic datapath.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- A  input  WIDTH  minuend, captured on accepted start
- B  input  WIDTH  subtrahend, captured on accepted start
- borrow_in  input  1  initial borrow, captured on accepted start
- busy  output  1  high while in SHIFT or DONE
- done  output  1  one-cycle pulse, result valid
- diff  output  WIDTH  registered difference
- borrow_out  output  1  final borrow (1 means unsigned A < B + borrow_in)

Behaviour:
- Reset/clock: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: busy=0, done=0, diff=0, borrow_out=0, state=IDLE, bit counter=0, operand registers=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at a rising edge latches A into a_sh, B into b_sh, borrow_in into br.
  - Clears the counter and enters SHIFT.
  - start=0: remain in IDLE; diff and borrow_out hold their previous values.
- SHIFT, each edge:
  - d = a_sh[0] ^ b_sh[0] ^ br.
  - br <= (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br).
  - diff <= {d, diff[WIDTH-1:1]}; a_sh and b_sh shift right by 1; counter increments.
  - On the edge that processes bit WIDTH-1: borrow_out <= new br, state <= DONE.
- DONE: done=1 for exactly one cycle, then IDLE on the next edge.
- Latency: start sampled at edge 0 → done high in the cycle after edge WIDTH (WIDTH+1 cycles from the start edge to returning to IDLE).
- busy = (state != IDLE). While busy=1, diff is intermediate and not valid.
- start while busy (SHIFT or DONE) is ignored and not queued. A, B and borrow_in may change freely after capture.
- Arithmetic: modulo 2^WIDTH; diff == (A - B - borrow_in) mod 2^WIDTH.
- Boundaries: all-zero and all-ones operands need no special case. Counter wrap occurs only at the SHIFT→DONE transition.
- Reset asserted mid-operation: immediate return to reset values, no done pulse. A new start is accepted on the first edge after release.

Optional Feature:
- Macro SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit) = signed two's-complement overflow = borrow into MSB XOR borrow out of MSB.
  - Registered alongside borrow_out on the final SHIFT edge; resets to 0; holds like diff.
- Undefined: no ovf port and no extra logic; behaviour otherwise identical.

Test Plan:
- Reset, then A=0, B=0, borrow_in=0, start pulse → done after 9 edges, diff=8'h00, borrow_out=0, ovf=0; busy high for exactly 9 cycles.
- A=0, B=1 → diff=8'hFF, borrow_out=1, ovf=0.
- A=8'h80, B=1 → diff=8'h7F, borrow_out=0, ovf=1 (when SERIAL_SUB_OVF_EN is defined).
- A=8'h80, B=8'h80, borrow_in=1 → diff=8'hFF, borrow_out=1. Also A=9, B=4 → diff=8'h05, borrow_out=0.
- Start A=200, B=100; pulse start again with A=1, B=1 during SHIFT → result diff=8'd100, single done pulse.
- Assert rst_n=0 at the 4th SHIFT cycle → busy, done, diff, borrow_out all 0 immediately. Fresh start A=4, B=5 after release → diff=8'hFF, borrow_out=1.
